// File: rtl/sb_spi_pkg.sv
// Shared constants for the slave-only SPI block: register addresses
// and the bit positions of status and control fields.
package sb_spi_pkg;

  localparam logic [7:0] ADDR_CR0  = 8'h08;
  localparam logic [7:0] ADDR_CR1  = 8'h09;
  localparam logic [7:0] ADDR_CR2  = 8'h0A;
  localparam logic [7:0] ADDR_BR   = 8'h0B;
  localparam logic [7:0] ADDR_SR   = 8'h0C;
  localparam logic [7:0] ADDR_TXDR = 8'h0D;
  localparam logic [7:0] ADDR_RXDR = 8'h0E;
  localparam logic [7:0] ADDR_CSR  = 8'h0F;

  localparam int SR_TIP  = 7;
  localparam int SR_BUSY = 6;
  localparam int SR_TOE  = 5;
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;
  localparam int SR_ROE  = 2;

  localparam int CR1_SPE  = 7;
  localparam int CR2_LSBF = 0;

endpackage

// File: rtl/sb_spi_sync.sv
// Multi-stage input synchronizer with rise/fall pulses on the synced value.
// Ports: clk, rst_n, d (async input) -> q (synced), rise, fall (1-cycle pulses).
module sb_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= STAGES'({chain, d});
      prev  <= q;
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/sb_spi_slave.sv
// Slave-only SPI block (mode 0) behind an 8-bit strobe/ack register bus.
// Ports: sb* system bus, spi_* pins; spi_mi unused, spi_mo tied low.
module sb_spi_slave
  import sb_spi_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sbstbi,
  input  logic       sbrwi,
  input  logic [7:0] sbadri,
  input  logic [7:0] sbdati,
  output logic [7:0] sbdato,
  output logic       sbacko,
  input  logic       spi_scki,
  input  logic       spi_scsni,
  input  logic       spi_si,
  output logic       spi_so,
  input  logic       spi_mi,
  output logic       spi_mo
);

  logic [7:0] cr0, cr1, cr2, br, csr;
  logic [7:0] txdr, rxdr, sr, rdata;
  logic [7:0] tx_sr, rx_sr, rx_nxt;
  logic [2:0] bit_cnt;
  logic       trdy, rrdy, roe, toe;
  logic       sck_q, sck_rise, sck_fall;
  logic       ss_q, ss_fall, mosi_q;
  logic       ss_rise_unused, mosi_rise_unused;
  logic       mosi_fall_unused, sck_q_unused;
  logic       spi_mi_unused;
  logic       spe, lsbf, active, acc, wr, rd;
  logic       rd_rx, rd_sr, wr_tx, load, complete;

  sb_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .d(spi_scki),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  sb_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(spi_scsni),
    .q(ss_q), .rise(ss_rise_unused), .fall(ss_fall)
  );

  sb_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_si),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign sck_q_unused  = sck_q;
  assign spi_mi_unused = spi_mi;
  assign spi_mo        = 1'b0;

  assign spe    = cr1[CR1_SPE];
  assign lsbf   = cr2[CR2_LSBF];
  assign active = spe & ~ss_q;

  // A strobe held through its ack cycle must not start a second access.
  assign acc   = sbstbi & ~sbacko;
  assign wr    = acc & sbrwi;
  assign rd    = acc & ~sbrwi;
  assign rd_rx = rd & (sbadri == ADDR_RXDR);
  assign rd_sr = rd & (sbadri == ADDR_SR);
  assign wr_tx = wr & (sbadri == ADDR_TXDR);

  assign complete = active & ~ss_fall & sck_rise & (bit_cnt == 3'd7);
  assign load     = active & (ss_fall | complete);

  assign rx_nxt = lsbf ? {mosi_q, rx_sr[7:1]} : {rx_sr[6:0], mosi_q};
  assign spi_so = active & (lsbf ? tx_sr[0] : tx_sr[7]);

  always_comb begin
    sr          = '0;
    sr[SR_TIP]  = |bit_cnt;
    sr[SR_BUSY] = active;
    sr[SR_TOE]  = toe;
    sr[SR_TRDY] = trdy;
    sr[SR_RRDY] = rrdy;
    sr[SR_ROE]  = roe;
  end

  always_comb begin
    rdata = '0;
    case (sbadri)
      ADDR_CR0:  rdata = cr0;
      ADDR_CR1:  rdata = cr1;
      ADDR_CR2:  rdata = cr2;
      ADDR_BR:   rdata = br;
      ADDR_SR:   rdata = sr;
      ADDR_RXDR: rdata = rxdr;
      ADDR_CSR:  rdata = csr;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbacko <= 1'b0;
      sbdato <= '0;
    end else begin
      sbacko <= acc;
      sbdato <= rd ? rdata : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr0 <= '0;
      cr1 <= '0;
      cr2 <= '0;
      br  <= '0;
      csr <= '0;
    end else if (wr) begin
      case (sbadri)
        ADDR_CR0: cr0 <= sbdati;
        ADDR_CR1: cr1 <= sbdati;
        ADDR_CR2: cr2 <= sbdati;
        ADDR_BR:  br  <= sbdati;
        ADDR_CSR: csr <= sbdati;
        default:  ;
      endcase
    end
  end

  // Fall shifts are skipped at count 0 so the byte just loaded on the
  // 8th rising edge is not advanced by the trailing falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else begin
      if (!active || ss_fall) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_nxt;
      end else if (sck_fall && bit_cnt != 3'd0) begin
        tx_sr <= lsbf ? (tx_sr >> 1) : (tx_sr << 1);
      end
      if (load) tx_sr <= trdy ? TX_IDLE_BYTE : txdr;
    end
  end

  // Later assignments take priority: byte completion beats an RXDR
  // read, and a TXDR write beats the load that consumed the old TRDY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txdr <= '0;
      rxdr <= '0;
      trdy <= 1'b1;
      rrdy <= 1'b0;
      roe  <= 1'b0;
      toe  <= 1'b0;
    end else begin
      if (rd_rx) begin
        rrdy <= 1'b0;
        roe  <= 1'b0;
      end
      if (rd_sr) begin
        toe <= 1'b0;
        roe <= 1'b0;
      end
      if (complete) begin
        rxdr <= rx_nxt;
        rrdy <= 1'b1;
        if (rrdy && !rd_rx) roe <= 1'b1;
      end
      if (load) begin
        if (trdy) toe  <= 1'b1;
        else      trdy <= 1'b1;
      end
      if (wr_tx) begin
        txdr <= sbdati;
        trdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sb_spi_slave.sv
// Bench for sb_spi_slave: directed bus and SPI master stimulus,
// read data checked against a queue of expected values.
module tb_sb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sbstbi = 1'b0;
  logic       sbrwi = 1'b0;
  logic [7:0] sbadri = '0;
  logic [7:0] sbdati = '0;
  logic [7:0] sbdato;
  logic       sbacko;
  logic       spi_scki = 1'b0;
  logic       spi_scsni = 1'b1;
  logic       spi_si = 1'b0;
  logic       spi_so;
  logic       spi_mi = 1'b0;
  logic       spi_mo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  sb_spi_slave #(.SYNC_STAGES(2), .TX_IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .sbstbi(sbstbi), .sbrwi(sbrwi), .sbadri(sbadri),
    .sbdati(sbdati), .sbdato(sbdato), .sbacko(sbacko),
    .spi_scki(spi_scki), .spi_scsni(spi_scsni),
    .spi_si(spi_si), .spi_so(spi_so),
    .spi_mi(spi_mi), .spi_mo(spi_mo)
  );

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && sbacko === 1'b1 && sbrwi === 1'b0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %02h want none", sbdato);
      end else begin
        e = sb_q.pop_front();
        check(e.name, sbdato, e.val);
      end
    end
  end

  task automatic bus(input logic rw, input logic [7:0] a,
                     input logic [7:0] d, input string name);
    int n;
    @(negedge clk);
    sbstbi = 1'b1;
    sbrwi  = rw;
    sbadri = a;
    sbdati = d;
    if (!rw) sb_q.push_back('{name: name, val: d});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sbacko !== 1'b1 && n < 16);
    check({name, "_ack_lat"}, 8'(n), 8'd1);
    sbstbi = 1'b0;
    @(negedge clk);
    check({name, "_ack_width"}, {7'b0, sbacko}, 8'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus(1'b1, a, d, $sformatf("wr%02h", a));
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                    input string name);
    bus(1'b0, a, exp, name);
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_scsni = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk);
    spi_scsni = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // SCK = clk/8: 4 cycles low (MOSI set, MISO sampled at end), 4 high.
  task automatic xfer(input logic [7:0] mo, input int nbits,
                      input bit lsb, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_si = lsb ? mo[i] : mo[7-i];
      repeat (4) @(negedge clk);
      if (lsb) mi[i] = spi_so;
      else     mi[7-i] = spi_so;
      spi_scki = 1'b1;
      repeat (4) @(negedge clk);
      spi_scki = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] mi;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {7'b0, sbacko}, 8'd0);
    check("rst_dato", sbdato, 8'h00);
    check("rst_so", {7'b0, spi_so}, 8'd0);
    check("rst_mo", {7'b0, spi_mo}, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // bus init and readback
    wr(8'h08, 8'h00);
    wr(8'h09, 8'h80);
    wr(8'h0A, 8'h01);
    wr(8'h0B, 8'h00);
    wr(8'h0F, 8'h00);
    rd(8'h08, 8'h00, "cr0");
    rd(8'h09, 8'h80, "cr1");
    rd(8'h0A, 8'h01, "cr2");
    rd(8'h0B, 8'h00, "br");
    rd(8'h0F, 8'h00, "csr");
    rd(8'h0C, 8'h10, "sr_init");
    wr(8'h0B, 8'h3C);
    wr(8'h0F, 8'hC3);
    wr(8'h03, 8'hFF);
    rd(8'h0B, 8'h3C, "br2");
    rd(8'h0F, 8'hC3, "csr2");
    rd(8'h03, 8'h00, "unmapped");

    // RX, LSB first
    ss_low();
    xfer(8'h11, 8, 1'b1, mi);
    check("rx_miso_idle", mi, 8'h00);
    ss_high();
    rd(8'h0C, 8'h38, "rx_sr");
    rd(8'h0E, 8'h11, "rx_rxdr");
    rd(8'h0C, 8'h10, "rx_sr_after");

    // TX echo
    wr(8'h0D, 8'h40);
    rd(8'h0D, 8'h00, "txdr_rd");
    rd(8'h0C, 8'h00, "tx_trdy0");
    ss_low();
    rd(8'h0C, 8'h50, "tx_busy_trdy1");
    xfer(8'h22, 8, 1'b1, mi);
    check("tx_miso1", mi, 8'h40);
    xfer(8'h33, 8, 1'b1, mi);
    check("tx_miso2", mi, 8'h00);
    ss_high();
    rd(8'h0C, 8'h3C, "tx_sr_toe");
    rd(8'h0C, 8'h18, "tx_sr_cleared");
    rd(8'h0E, 8'h33, "tx_rxdr");
    rd(8'h0C, 8'h10, "tx_sr_end");

    // overrun
    ss_low();
    xfer(8'hA5, 8, 1'b1, mi);
    xfer(8'h5A, 8, 1'b1, mi);
    ss_high();
    rd(8'h0C, 8'h3C, "ovr_sr");
    rd(8'h0E, 8'h5A, "ovr_rxdr");
    rd(8'h0C, 8'h10, "ovr_sr_end");

    // MSB first
    wr(8'h0A, 8'h00);
    wr(8'h0D, 8'h80);
    ss_low();
    xfer(8'h01, 8, 1'b0, mi);
    check("msb_first_bit", {7'b0, mi[7]}, 8'd1);
    check("msb_miso", mi, 8'h80);
    ss_high();
    rd(8'h0E, 8'h01, "msb_rxdr");
    rd(8'h0C, 8'h30, "msb_sr");
    wr(8'h0A, 8'h01);

    // SS abort after 3 bits, then a full byte
    ss_low();
    xfer(8'hFF, 3, 1'b1, mi);
    ss_high();
    rd(8'h0C, 8'h30, "abort_sr");
    ss_low();
    xfer(8'hC6, 8, 1'b1, mi);
    ss_high();
    rd(8'h0E, 8'hC6, "abort_rxdr");
    rd(8'h0C, 8'h30, "abort_sr2");

    // reset mid-byte
    wr(8'h0D, 8'h99);
    ss_low();
    xfer(8'hFF, 4, 1'b1, mi);
    check("pre_rst_miso", mi, 8'h09);
    repeat (4) @(negedge clk);
    check("pre_rst_so", {7'b0, spi_so}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_so", {7'b0, spi_so}, 8'd0);
    check("mid_rst_ack", {7'b0, sbacko}, 8'd0);
    spi_scsni = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(8'h08, 8'h00, "post_cr0");
    rd(8'h09, 8'h00, "post_cr1");
    rd(8'h0A, 8'h00, "post_cr2");
    rd(8'h0B, 8'h00, "post_br");
    rd(8'h0C, 8'h10, "post_sr");
    rd(8'h0E, 8'h00, "post_rxdr");
    rd(8'h0F, 8'h00, "post_csr");
    check("post_so", {7'b0, spi_so}, 8'd0);

    repeat (2) @(negedge clk);
    check("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sb_spi_slave.md
Name: sb_spi_slave

Overview:
- Synthesizable model of the iCE40 UltraPlus hard SPI block, restricted to slave operation.
- Host logic programs it and moves data through an 8-bit system-bus register interface: strobe, read/write, address, data in/out and a one-cycle ack.
- It shifts bytes on an external SPI slave link (SCK/SS/MOSI/MISO) in mode 0 and sits between the SPI pins and the command FSM of the top level.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for the SCK/SS/MOSI inputs.
- TX_IDLE_BYTE, 8'h00, byte shifted out when no new byte has been written to TXDR.

Ports:
- clk  in  1  system clock (SBCLKI); all logic is in this domain.
- rst_n  in  1  asynchronous active-low reset.
- sbstbi  in  1  bus strobe; held high until ack.
- sbrwi  in  1  1 = write, 0 = read.
- sbadri  in  8  register address.
- sbdati  in  8  write data.
- sbdato  out  8  read data, valid in the ack cycle.
- sbacko  out  1  one-cycle transfer acknowledge.
- spi_scki  in  1  SPI clock from the master.
- spi_scsni  in  1  slave select, active low.
- spi_si  in  1  MOSI.
- spi_so  out  1  MISO.
- spi_mi  in  1  master-in; unused.
- spi_mo  out  1  master-out; driven 0.

Behaviour:
- Register map (unmapped addresses read 0, ignore writes, still ack):
  - 0x08 SPICR0, 0x0B SPIBR, 0x0F SPICSR: read/write storage only.
  - 0x09 SPICR1: bit7 SPE enables the SPI side.
  - 0x0A SPICR2: bit0 LSBF (1 = LSB first); other bits are stored and ignored (always slave, mode 0).
  - 0x0C SPISR, read-only:
    - bit7 TIP: bit count not 0.
    - bit6 BUSY: SS low and SPE set.
    - bit5 TOE, bit4 TRDY, bit3 RRDY, bit2 ROE; others 0.
  - 0x0D SPITXDR: write-only; reads return 0.
  - 0x0E SPIRXDR: read-only.
- Reset:
  - All control registers, RXDR and TXDR are 0.
  - TRDY=1; RRDY=ROE=TOE=0; sbacko=0; sbdato=0; spi_so=0; spi_mo=0; bit counter 0.
- Bus handshake:
  - sbacko registers as sbstbi && !sbacko, so ack comes 1 cycle after strobe is sampled.
  - If strobe stays high, ack is never asserted twice in a row; a strobe held through the ack cycle starts no new transfer.
  - Write data and read side effects take effect at the edge that raises ack.
  - sbdato holds the addressed value in the ack cycle.
- Read side effects:
  - Reading RXDR clears RRDY and ROE.
  - Reading SPISR clears TOE and ROE after returning their current values.
- TXDR write: stores the byte and clears TRDY.
- SPI input capture:
  - SCK, SS and MOSI pass through SYNC_STAGES flip-flops before edge detection.
  - Supported SCK frequency is at most clk/8.
- Mode 0 framing:
  - Byte load happens on SS falling, and again after every 8th sampled SCK rising edge while SS stays low.
  - At a load, the shifter takes TXDR if TRDY=0 and then sets TRDY=1. Otherwise it takes TX_IDLE_BYTE and sets TOE=1.
  - spi_so presents the first bit immediately after a load.
  - MOSI is sampled on each synchronized SCK rising edge.
  - spi_so advances on each synchronized SCK falling edge.
  - Bit order is LSB first if LSBF=1, else MSB first; the same order applies to TX and RX.
- Byte completion (8th rising edge):
  - The received byte goes into RXDR and RRDY is set.
  - If RRDY was already 1, ROE is set and RXDR is overwritten.
- SS rising mid-byte: the bit counter resets to 0, the partial byte is discarded, and no flags change.
- SS high: spi_so=0.
- SPE=0: SCK/SS are ignored, the shifter is idle, spi_so=0, and bus registers stay fully accessible.
- Simultaneous events:
  - A bus RXDR read and a byte completion in the same cycle: the new byte wins, RRDY stays 1, ROE is not set.
  - A TXDR write and a load in the same cycle: the load takes the old state, and the write then clears TRDY.
- Reset asserted mid-operation clears everything to reset values immediately.

Decomposition:
- Shared package sb_spi_pkg holds:
  - the register address constants (0x08–0x0F);
  - the SPISR bit indices;
  - the SPICR1.SPE and SPICR2.LSBF indices.
- One sub-module, sb_spi_sync, a SYNC_STAGES-deep synchronizer with rise/fall edge outputs, instantiated for SCK and SS (MOSI uses the sync only).
- The register file, bus handshake and shifter live in the top module.

Test Plan:
- Bus init: write 0x00→0x08, 0x80→0x09, 0x01→0x0A, 0x00→0x0B, 0x00→0x0F with strobe held until ack, then read each back.
  - Each ack is exactly 1 cycle, 1 cycle after strobe.
  - Reads return the written values.
  - SPISR reads 0x10.
- RX, LSB first: master sends 0x11 (SCK=clk/8).
  - RRDY=1 and SPISR bit3 set.
  - RXDR read returns 0x11.
  - A following SPISR read shows RRDY=0.
- TX echo: write 0x40 to TXDR (TRDY→0), then master clocks 2 bytes.
  - MISO first byte = 0x40 (LSB first), and TRDY returns to 1 at load.
  - Second byte = 0x00 and TOE=1; a later SPISR read clears TOE.
- Overrun: master sends 0xA5 then 0x5A without any RXDR read.
  - ROE=1.
  - RXDR=0x5A.
- MSB first: LSBF=0, TXDR=0x80, master sends 0x01.
  - MISO first bit is 1.
  - RXDR=0x01.
- Abort/reset: SS rises after 3 bits → RRDY stays 0 and the next byte is received intact; rst_n low mid-byte → all registers at reset values, TRDY=1, spi_so=0.
